// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX branches against fetch predictions, redirects on miss, queues predictor updates.
package branch_resolve_pkg;
  typedef enum logic [1:0] {NO_SPEC, BRANCH, JUMP, RAS} spec_type_e;
endpackage

module branch_resolve_unit
  import branch_resolve_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int UPD_DEPTH = 4,
  parameter int CNT_W     = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            ex_valid_i,
  input  logic            ex_bjtype_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_pc_incr_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_pc_i,
  input  spec_type_e      ex_spectype_i,
  input  logic            ex_act_taken_i,
  input  logic [XLEN-1:0] ex_act_target_i,
  output logic            spec_hit_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            upd_valid_o,
  input  logic            upd_ready_i,
  output logic [XLEN-1:0] upd_pc_o,
  output logic [XLEN-1:0] upd_target_o,
  output logic            upd_taken_o,
  output spec_type_e      upd_spectype_o,
  output logic            upd_miss_o,
  output logic [CNT_W-1:0] cnt_branch_o,
  output logic [CNT_W-1:0] cnt_miss_o,
  output logic [CNT_W-1:0] cnt_drop_o
);
  localparam int AW = $clog2(UPD_DEPTH);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
    spec_type_e      spectype;
    logic            miss;
  } upd_t;
  upd_t mem [UPD_DEPTH];
  upd_t head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic squash_q, res, miss, mispredict, push_req, push, pop, full, empty, drop;
  logic [XLEN-1:0] next_pc;
  // The instruction right behind a miss is on the wrong path; squash lasts as long as the redirect pulse.
  assign squash_q = redirect_valid_o;
  always_comb begin
    res        = ex_valid_i && !stall_i && !squash_q;
    miss       = ex_bjtype_i ? (ex_pred_taken_i != ex_act_taken_i) ||
                               (ex_act_taken_i && ex_pred_pc_i != ex_act_target_i)
                             : ex_pred_taken_i;
    mispredict = res && miss;
    next_pc    = ex_act_taken_i && ex_bjtype_i ? ex_act_target_i : ex_pc_incr_i;
    push_req   = res && ex_bjtype_i;
    empty      = wr_ptr == rd_ptr;
    full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop        = !empty && upd_ready_i;
    push       = push_req && (!full || pop);
    drop       = push_req && full && !pop;
  end
  assign spec_hit_o     = !mispredict;
  assign head           = mem[rd_ptr[AW-1:0]];
  assign upd_valid_o    = !empty;
  assign upd_pc_o       = head.pc;
  assign upd_target_o   = head.target;
  assign upd_taken_o    = head.taken;
  assign upd_spectype_o = head.spectype;
  assign upd_miss_o     = head.miss;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else if (!stall_i) begin
      redirect_valid_o <= mispredict;
      if (mispredict) redirect_pc_o <= next_pc;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{pc: ex_pc_i, target: ex_act_target_i, taken: ex_act_taken_i,
                                       spectype: ex_spectype_i, miss: miss};
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_branch_o <= '0;
      cnt_miss_o   <= '0;
      cnt_drop_o   <= '0;
    end else begin
      if (push_req && !(&cnt_branch_o)) cnt_branch_o <= cnt_branch_o + CNT_W'(1);
      if (mispredict && !(&cnt_miss_o)) cnt_miss_o <= cnt_miss_o + CNT_W'(1);
      if (drop && !(&cnt_drop_o)) cnt_drop_o <= cnt_drop_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vector table plus hand sequences for squash, FIFO overflow, stall and reset.
module tb_branch_resolve_unit;
  import branch_resolve_pkg::*;
  logic clk = 1'b0, rst_n, stall, ex_valid, ex_bj, pt, at, ready;
  logic [31:0] ex_pc, ex_incr, ppc, tgt;
  spec_type_e st;
  logic spec_hit, rv, upd_valid, upd_taken, upd_miss;
  logic [31:0] rpc, upd_pc, upd_target, cnt_branch, cnt_miss, cnt_drop;
  spec_type_e upd_st;
  int total = 0, bad = 0;

  branch_resolve_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .ex_valid_i(ex_valid), .ex_bjtype_i(ex_bj),
    .ex_pc_i(ex_pc), .ex_pc_incr_i(ex_incr), .ex_pred_taken_i(pt), .ex_pred_pc_i(ppc),
    .ex_spectype_i(st), .ex_act_taken_i(at), .ex_act_target_i(tgt), .spec_hit_o(spec_hit),
    .redirect_valid_o(rv), .redirect_pc_o(rpc), .upd_valid_o(upd_valid), .upd_ready_i(ready),
    .upd_pc_o(upd_pc), .upd_target_o(upd_target), .upd_taken_o(upd_taken),
    .upd_spectype_o(upd_st), .upd_miss_o(upd_miss), .cnt_branch_o(cnt_branch),
    .cnt_miss_o(cnt_miss), .cnt_drop_o(cnt_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic bj, input logic [31:0] pc, input logic ptk, input logic [31:0] ppcv,
                        input logic atk, input logic [31:0] tg, input spec_type_e s);
    ex_valid = 1'b1; ex_bj = bj; ex_pc = pc; ex_incr = pc + 32'd4;
    pt = ptk; ppc = ppcv; at = atk; tgt = tg; st = s;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; ex_valid = 1'b0; stall = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  typedef struct {
    string name;
    logic bj; logic [31:0] pc; logic ptk; logic [31:0] ppcv; logic atk; logic [31:0] tg; spec_type_e s;
    logic hit; logic [31:0] rpc;
  } vec_t;
  vec_t vecs [10];

  logic [31:0] exp_rpc, exp_branch, exp_miss;
  logic [31:0] drain [4];

  initial begin
    vecs[0] = '{"bne_hit",    1, 32'h80000100, 1, 32'h80000140, 1, 32'h80000140, BRANCH,  1, 32'h0};
    vecs[1] = '{"beq_nt_miss",1, 32'h80000100, 0, 32'h80000104, 1, 32'h80000200, BRANCH,  0, 32'h80000200};
    vecs[2] = '{"jalr_ras",   1, 32'h80000120, 1, 32'h80000300, 1, 32'h80000310, RAS,     0, 32'h80000310};
    vecs[3] = '{"phantom",    0, 32'h80000400, 1, 32'h80000500, 0, 32'h0,        BRANCH,  0, 32'h80000404};
    vecs[4] = '{"nt_hit",     1, 32'h80000600, 0, 32'h80000604, 0, 32'h80000700, NO_SPEC, 1, 32'h0};
    vecs[5] = '{"t_pred_nt",  1, 32'h80000610, 1, 32'h80000700, 0, 32'h80000700, BRANCH,  0, 32'h80000614};
    vecs[6] = '{"bad_target", 1, 32'h80000620, 1, 32'h80000700, 1, 32'h80000704, JUMP,    0, 32'h80000704};
    vecs[7] = '{"alu_nopred", 0, 32'h80000630, 0, 32'h80000634, 0, 32'h0,        NO_SPEC, 1, 32'h0};
    vecs[8] = '{"jal_hit",    1, 32'h80000640, 1, 32'h80000800, 1, 32'h80000800, JUMP,    1, 32'h0};
    vecs[9] = '{"alu_acttk",  0, 32'h80000650, 0, 32'h80000654, 1, 32'h80000900, NO_SPEC, 1, 32'h0};

    ready = 1'b1;
    set_ex(0, 0, 0, 0, 0, 0, NO_SPEC);
    rst_n = 1'b0; stall = 1'b0; ex_valid = 1'b0;
    tick; tick;
    chk("reset_rv", rv, 0);
    chk("reset_rpc", rpc, 0);
    chk("reset_upd_valid", upd_valid, 0);
    chk("reset_cnt_branch", cnt_branch, 0);
    chk("reset_spec_hit", spec_hit, 1);
    rst_n = 1'b1;
    tick;

    exp_rpc = 0; exp_branch = 0; exp_miss = 0;
    for (int i = 0; i < 10; i++) begin
      set_ex(vecs[i].bj, vecs[i].pc, vecs[i].ptk, vecs[i].ppcv, vecs[i].atk, vecs[i].tg, vecs[i].s);
      #1 chk({vecs[i].name, "_hit"}, spec_hit, vecs[i].hit);
      if (!vecs[i].hit) begin
        exp_rpc = vecs[i].rpc;
        exp_miss++;
      end
      if (vecs[i].bj) exp_branch++;
      tick;
      ex_valid = 1'b0;
      chk({vecs[i].name, "_rv"}, rv, !vecs[i].hit);
      chk({vecs[i].name, "_rpc"}, rpc, exp_rpc);
      chk({vecs[i].name, "_upd_valid"}, upd_valid, vecs[i].bj);
      if (vecs[i].bj) begin
        chk({vecs[i].name, "_upd_pc"}, upd_pc, vecs[i].pc);
        chk({vecs[i].name, "_upd_target"}, upd_target, vecs[i].tg);
        chk({vecs[i].name, "_upd_taken"}, upd_taken, vecs[i].atk);
        chk({vecs[i].name, "_upd_spectype"}, upd_st, vecs[i].s);
        chk({vecs[i].name, "_upd_miss"}, upd_miss, !vecs[i].hit);
      end
      tick;
      chk({vecs[i].name, "_rv_clear"}, rv, 0);
      chk({vecs[i].name, "_drained"}, upd_valid, 0);
    end
    chk("tbl_cnt_branch", cnt_branch, exp_branch);
    chk("tbl_cnt_miss", cnt_miss, exp_miss);
    chk("tbl_cnt_drop", cnt_drop, 0);

    // wrong-path instruction right after a miss is ignored
    do_reset;
    ready = 1'b0;
    set_ex(1, 32'h80000100, 0, 32'h80000104, 1, 32'h80000200, BRANCH);
    tick;
    set_ex(1, 32'h80000200, 1, 32'h80000900, 0, 32'h80000900, BRANCH);
    #1 chk("squash_hit", spec_hit, 1);
    chk("squash_rv", rv, 1);
    tick;
    ex_valid = 1'b0;
    chk("squash_rv_clear", rv, 0);
    chk("squash_cnt_branch", cnt_branch, 1);
    chk("squash_cnt_miss", cnt_miss, 1);
    chk("squash_head_pc", upd_pc, 32'h80000100);
    ready = 1'b1;
    tick;
    chk("squash_one_entry", upd_valid, 0);

    // overflow: six pushes into four entries, then push+pop while full, then drain
    do_reset;
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_ex(1, 32'h80001000 + 32'(i * 16), 0, 32'h0, 0, 32'h80003000, BRANCH);
      tick;
    end
    chk("ovf_cnt_branch", cnt_branch, 6);
    chk("ovf_cnt_drop", cnt_drop, 2);
    chk("ovf_valid", upd_valid, 1);
    chk("ovf_head", upd_pc, 32'h80001000);
    ready = 1'b1;
    set_ex(1, 32'h80002000, 0, 32'h0, 0, 32'h80003000, BRANCH);
    tick;
    ex_valid = 1'b0;
    chk("full_pushpop_drop", cnt_drop, 2);
    drain = '{32'h80001010, 32'h80001020, 32'h80001030, 32'h80002000};
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", upd_valid, 1);
      chk("drain_pc", upd_pc, drain[i]);
      tick;
    end
    chk("drain_empty", upd_valid, 0);

    // redirect held through a 3-cycle stall
    do_reset;
    set_ex(1, 32'h80000500, 0, 32'h80000504, 1, 32'h80000800, BRANCH);
    tick;
    stall = 1'b1;
    set_ex(1, 32'h80000800, 1, 32'h80000000, 0, 32'h80000000, BRANCH);
    for (int i = 0; i < 3; i++) begin
      chk("stall_rv_held", rv, 1);
      chk("stall_spec_hit", spec_hit, 1);
      tick;
    end
    stall = 1'b0;
    ex_valid = 1'b0;
    chk("unstall_rv", rv, 1);
    chk("unstall_rpc", rpc, 32'h80000800);
    tick;
    chk("unstall_rv_clear", rv, 0);
    chk("stall_cnt_branch", cnt_branch, 1);

    // reset in the middle of a stalled redirect
    ready = 1'b0;
    set_ex(1, 32'h80000900, 1, 32'h80000a00, 0, 32'h80000a00, BRANCH);
    tick;
    stall = 1'b1;
    ex_valid = 1'b0;
    chk("pre_rst_rpc", rpc, 32'h80000904);
    chk("pre_rst_valid", upd_valid, 1);
    tick;
    chk("pre_rst_rv", rv, 1);
    rst_n = 1'b0;
    tick;
    chk("mid_rst_rv", rv, 0);
    chk("mid_rst_rpc", rpc, 0);
    chk("mid_rst_upd_valid", upd_valid, 0);
    chk("mid_rst_cnt_branch", cnt_branch, 0);
    chk("mid_rst_cnt_miss", cnt_miss, 0);
    chk("mid_rst_cnt_drop", cnt_drop, 0);
    rst_n = 1'b1;
    stall = 1'b0;
    tick;
    chk("post_rst_rv", rv, 0);
    chk("post_rst_upd_valid", upd_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
